// File: rtl/imem_arb_if.sv
// Bus bundle between imem_arb, its two requesters (fetch, debug) and the imem read port.
// slave = arbiter side, master = requester/memory side.
interface imem_arb_if #(
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [DATA_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              dbg_req;
    logic [DATA_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_err;

    logic [DATA_W-1:0] imem_addr;
    logic              imem_stop;
    logic [DATA_W-1:0] imem_data;

    modport slave (
        input  if_req, if_addr, dbg_req, dbg_addr, imem_data,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        output imem_addr, imem_stop
    );

    modport master (
        output if_req, if_addr, dbg_req, dbg_addr, imem_data,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        input  imem_addr, imem_stop
    );
endinterface

// File: rtl/imem_arb.sv
// Fetch/debug arbiter for the single-port synchronous-read imem; fetch has priority, debug is
// served after at most MAX_BURST fetch grants. Define IMEM_ARB_MISALIGN_EN to error misaligned reads.
module imem_arb #(
    parameter int MAX_BURST = 4,
    parameter int DATA_W    = 32
) (
    input logic       clk,
    input logic       rst_n,
    imem_arb_if.slave bus
);
    typedef enum logic {S_IF, S_DBG} state_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t            state;
    logic [3:0]        burst_cnt;
    logic [DATA_W-1:0] last_addr;

    logic              if_gnt_p0;
    logic              dbg_gnt_p0;
    logic [DATA_W-1:0] gnt_addr_p0;
    logic              any_gnt_p0;
    logic              misalign_p0;
    logic              issue_p0;

    logic              vld_if_p1;
    logic              vld_dbg_p1;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= MAX_B) ? MAX_B : v + 4'd1;
    endfunction

    // ---- stage p0: grant and imem issue ----
    always_comb begin
        if_gnt_p0  = 1'b0;
        dbg_gnt_p0 = 1'b0;
        if (state == S_DBG) begin
            dbg_gnt_p0 = bus.dbg_req;
            if_gnt_p0  = bus.if_req & ~bus.dbg_req;
        end else begin
            if_gnt_p0  = bus.if_req;
            dbg_gnt_p0 = bus.dbg_req & ~bus.if_req;
        end
    end

    assign gnt_addr_p0 = if_gnt_p0 ? bus.if_addr : bus.dbg_addr;
    assign any_gnt_p0  = if_gnt_p0 | dbg_gnt_p0;

`ifdef IMEM_ARB_MISALIGN_EN
    assign misalign_p0 = any_gnt_p0 & (gnt_addr_p0[1:0] != 2'b00);
`else
    assign misalign_p0 = 1'b0;
`endif

    assign issue_p0      = any_gnt_p0 & ~misalign_p0;
    assign bus.if_gnt    = if_gnt_p0;
    assign bus.dbg_gnt   = dbg_gnt_p0;
    assign bus.imem_addr = issue_p0 ? gnt_addr_p0 : last_addr;
    assign bus.imem_stop = ~issue_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IF;
            burst_cnt  <= 4'd0;
            last_addr  <= '0;
            vld_if_p1  <= 1'b0;
            vld_dbg_p1 <= 1'b0;
        end else begin
            vld_if_p1  <= if_gnt_p0;
            vld_dbg_p1 <= dbg_gnt_p0;
            if (issue_p0) begin
                last_addr <= gnt_addr_p0;
            end
            case (state)
                S_IF: begin
                    // Only fetch grants taken while debug is waiting count toward the burst.
                    if (!bus.dbg_req || dbg_gnt_p0) begin
                        burst_cnt <= 4'd0;
                    end else if (if_gnt_p0) begin
                        burst_cnt <= sat_inc(burst_cnt);
                        if (sat_inc(burst_cnt) >= MAX_B) begin
                            state <= S_DBG;
                        end
                    end
                end
                S_DBG: begin
                    // Debug is either granted now or has withdrawn; either way hand back to fetch.
                    state     <= S_IF;
                    burst_cnt <= 4'd0;
                end
                default: begin
                    state     <= S_IF;
                    burst_cnt <= 4'd0;
                end
            endcase
        end
    end

    // ---- stage p1: route registered imem data to the owner ----
`ifdef IMEM_ARB_MISALIGN_EN
    logic err_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_p1 <= 1'b0;
        end else begin
            err_p1 <= misalign_p0;
        end
    end

    assign bus.if_rdata  = (vld_if_p1 && !err_p1) ? bus.imem_data : '0;
    assign bus.dbg_rdata = (vld_dbg_p1 && !err_p1) ? bus.imem_data : '0;
    assign bus.if_err    = vld_if_p1 & err_p1;
    assign bus.dbg_err   = vld_dbg_p1 & err_p1;
`else
    assign bus.if_rdata  = vld_if_p1 ? bus.imem_data : '0;
    assign bus.dbg_rdata = vld_dbg_p1 ? bus.imem_data : '0;
    assign bus.if_err    = 1'b0;
    assign bus.dbg_err   = 1'b0;
`endif

    assign bus.if_rvalid  = vld_if_p1;
    assign bus.dbg_rvalid = vld_dbg_p1;

endmodule
